// File: rtl/atmega_irq_pkg.sv
// Shared types and constants for the ATmega32A-style interrupt controller.
package atmega_irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2,
      HOLDOFF = 2'd3
   } irq_state_t;

   localparam int TIFR_TOV0  = 0;
   localparam int TIFR_OCF0  = 1;
   localparam int TIFR_TOV1  = 2;
   localparam int TIFR_OCF1B = 3;
   localparam int TIFR_OCF1A = 4;
   localparam int TIFR_ICF1  = 5;
   localparam int TIFR_TOV2  = 6;
   localparam int TIFR_OCF2  = 7;

   // External sources sit above the timer bits in the joint pending word.
   localparam int SRC_INT1 = 8;
   localparam int SRC_INT0 = 9;

   localparam logic [13:0] VEC_INT0       = 14'h002;
   localparam logic [13:0] VEC_INT1       = 14'h004;
   localparam logic [13:0] VEC_TIMER_BASE = 14'h008;

endpackage

// File: rtl/interrupt_controller_if.sv
// Handshake between the interrupt controller (master) and the control unit (slave).
interface interrupt_controller_if #(parameter int PC_W = 14);
   logic            boundary_i;
   logic            ack_i;
   logic            reti_i;
   logic            irq_req_o;
   logic [PC_W-1:0] vector_o;
   logic            clr_i_bit_o;
   logic            in_service_o;

   modport master (
      input  boundary_i, ack_i, reti_i,
      output irq_req_o, vector_o, clr_i_bit_o, in_service_o
   );

   modport slave (
      output boundary_i, ack_i, reti_i,
      input  irq_req_o, vector_o, clr_i_bit_o, in_service_o
   );
endinterface

// File: rtl/irq_priority_encoder.sv
// Fixed-priority pick over {INT0,INT1,TIFR[7:0]}; highest set bit wins.
module irq_priority_encoder
   import atmega_irq_pkg::*;
#(
   parameter int              PC_W     = 14,
   parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_TIMER_BASE)
) (
   input  logic [9:0]      pend_i,
   output logic            valid_o,
   output logic [3:0]      idx_o,
   output logic [PC_W-1:0] vec_o
);
   logic [2:0] idx_inv;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (pend_i[i]) begin
            valid_o = 1'b1;
            idx_o   = 4'(i);
         end
      end
      idx_inv = 3'd7 - idx_o[2:0];
      if (idx_o == 4'(SRC_INT0))
         vec_o = PC_W'(VEC_INT0);
      else if (idx_o == 4'(SRC_INT1))
         vec_o = PC_W'(VEC_INT1);
      else
         vec_o = VEC_BASE + PC_W'({idx_inv, 1'b0});
   end
endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: arbitrate, request, clear flag on ack, track ISR to RETI.
// Optional external INT0/INT1 sources: INTERRUPT_CONTROLLER_EXT_INT_EN.
module interrupt_controller
   import atmega_irq_pkg::*;
#(
   parameter int              PC_W     = 14,
   parameter logic [PC_W-1:0] VEC_BASE = PC_W'(VEC_TIMER_BASE)
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [7:0] tifr_i,
   input  logic [7:0] timsk_i,
   input  logic       i_bit_i,
`ifdef INTERRUPT_CONTROLLER_EXT_INT_EN
   input  logic [1:0] int_pin_i,
   input  logic [1:0] gicr_i,
   output logic [1:0] intf_o,
`endif
   output logic [7:0] tifr_clr_o,
   interrupt_controller_if.master bus
);
   irq_state_t      state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [PC_W-1:0] vec_q, vec_d;
   logic [7:0]      clr_q, clr_d;
   logic            clri_q, clri_d;
   logic [1:0]      ext_pend;
   logic [9:0]      pend_all;
   logic            enc_valid;
   logic [3:0]      enc_idx;
   logic [PC_W-1:0] enc_vec;

`ifdef INTERRUPT_CONTROLLER_EXT_INT_EN
   logic [1:0] s1_q, s2_q, s3_q, intf_q, intf_d, rise, ext_clr;

   assign rise    = s2_q & ~s3_q;
   assign ext_clr = {(state_q == PEND) && bus.ack_i && (idx_q == 4'(SRC_INT1)),
                     (state_q == PEND) && bus.ack_i && (idx_q == 4'(SRC_INT0))};
   // A fresh edge in the acceptance cycle keeps the flag set.
   assign intf_d   = (intf_q & ~ext_clr) | rise;
   assign ext_pend = {intf_q[0] & gicr_i[0], intf_q[1] & gicr_i[1]};
   assign intf_o   = intf_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s1_q   <= 2'b00;
         s2_q   <= 2'b00;
         s3_q   <= 2'b00;
         intf_q <= 2'b00;
      end else begin
         s1_q   <= int_pin_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         intf_q <= intf_d;
      end
   end
`else
   assign ext_pend = 2'b00;
`endif

   assign pend_all = {ext_pend, tifr_i & timsk_i};

   irq_priority_encoder #(.PC_W(PC_W), .VEC_BASE(VEC_BASE)) u_enc (
      .pend_i  (pend_all),
      .valid_o (enc_valid),
      .idx_o   (enc_idx),
      .vec_o   (enc_vec)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      clr_d   = 8'h00;
      clri_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.boundary_i && i_bit_i && enc_valid) begin
               idx_d   = enc_idx;
               vec_d   = enc_vec;
               state_d = PEND;
            end
         end
         PEND: begin
            if (bus.ack_i) begin
               state_d = SERVICE;
               clri_d  = 1'b1;
               if (!idx_q[3]) clr_d[idx_q[2:0]] = 1'b1;
            end else if (!i_bit_i || !pend_all[idx_q]) begin
               state_d = IDLE;
            end
         end
         SERVICE: if (bus.reti_i) state_d = HOLDOFF;
         HOLDOFF: if (bus.boundary_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         vec_q   <= '0;
         clr_q   <= 8'h00;
         clri_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         clr_q   <= clr_d;
         clri_q  <= clri_d;
      end
   end

   assign bus.irq_req_o    = (state_q == PEND);
   assign bus.vector_o     = vec_q;
   assign bus.clr_i_bit_o  = clri_q;
   assign bus.in_service_o = (state_q == SERVICE);
   assign tifr_clr_o       = clr_q;
endmodule
